// File: rtl/conv3x3_mac_pe.sv
// conv3x3_mac_pe: 3x3 convolution multiply-accumulate processing element, Q8.8 in and out.
// Weights k0..k8 and the bias are loaded through a write port. Each accepted window goes
// through a 4-stage pipeline: products, row sums, bias add, then round/ReLU/saturate.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   w_load/w_addr/w_data   - weight (0..8) / bias (9) write port; addresses 10..15 are ignored
//   w_clear                - clears the written-mask only; weight values are kept
//   valid_in, data_in0..8  - window strobe and taps, same order as k0..k8
//   relu_en                - ReLU select, captured together with the window
//   data_out, valid_out    - result, plus a one-cycle pulse when a result is produced
//   weights_ready          - all ten registers written since the last reset or clear
//   drop_err               - sticky: a window arrived before the weights were ready
module conv3x3_mac_pe #(
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w_load,
  input  logic [3:0]  w_addr,
  input  logic [15:0] w_data,
  input  logic        w_clear,
  input  logic        valid_in,
  input  logic [15:0] data_in0,
  input  logic [15:0] data_in1,
  input  logic [15:0] data_in2,
  input  logic [15:0] data_in3,
  input  logic [15:0] data_in4,
  input  logic [15:0] data_in5,
  input  logic [15:0] data_in6,
  input  logic [15:0] data_in7,
  input  logic [15:0] data_in8,
  input  logic        relu_en,
  output logic [15:0] data_out,
  output logic        valid_out,
  output logic        weights_ready,
  output logic        drop_err
);
  localparam int unsigned DW   = 16;
  localparam int unsigned PW   = 32;
  localparam int unsigned AW   = 36;
  localparam int unsigned NTAP = 9;
  localparam int unsigned NROW = 3;
  localparam int unsigned NREG = 10;
  localparam logic [3:0]  BIAS_ADDR = 4'd9;

  localparam logic signed [AW-1:0] HALF    = AW'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [AW-1:0] SAT_MAX = 36'sd32767;
  localparam logic signed [AW-1:0] SAT_MIN = -36'sd32768;
  localparam logic signed [DW-1:0] OUT_MAX = 16'sh7FFF;
  localparam logic signed [DW-1:0] OUT_MIN = 16'sh8000;

  logic signed [DW-1:0] din [NTAP];
  logic signed [DW-1:0] kern_q [NTAP];
  logic signed [DW-1:0] bias_q;
  logic [NREG-1:0]      mask_q, mask_d;
  logic                 ready_q, drop_q;
  logic                 wr_ok, accept;

  logic signed [PW-1:0] prod_q [NTAP];
  logic signed [DW-1:0] bias_s1_q, bias_s2_q;
  logic                 relu_s1_q, relu_s2_q, relu_s3_q;
  logic signed [AW-1:0] row_q [NROW];
  logic signed [AW-1:0] total_q;
  logic                 v1_q, v2_q, v3_q, vout_q;
  logic signed [DW-1:0] dout_q, dout_d;
  logic signed [AW-1:0] rnd;

  // Gather the window taps into an array in k0..k8 order.
  always_comb begin
    din[0] = data_in0;
    din[1] = data_in1;
    din[2] = data_in2;
    din[3] = data_in3;
    din[4] = data_in4;
    din[5] = data_in5;
    din[6] = data_in6;
    din[7] = data_in7;
    din[8] = data_in8;
  end

  assign wr_ok  = w_load && (w_addr <= BIAS_ADDR);
  assign accept = valid_in && ready_q;

  // Written-mask update; a same-cycle clear takes priority over the write's mask bit.
  always_comb begin
    mask_d = mask_q;
    if (w_clear) begin
      mask_d = '0;
    end else if (wr_ok) begin
      mask_d[w_addr] = 1'b1;
    end
  end

  // Weight/bias storage, readiness tracking and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAP; k++) kern_q[k] <= '0;
      bias_q  <= '0;
      mask_q  <= '0;
      ready_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        if (w_addr == BIAS_ADDR) bias_q <= w_data;
        else                     kern_q[w_addr] <= w_data;
      end
      mask_q  <= mask_d;
      ready_q <= &mask_d;
      if (valid_in && !ready_q) drop_q <= 1'b1;
    end
  end

  // Stage 4 combinational part: round half up, optional ReLU, saturate to 16 bits.
  always_comb begin
    rnd    = (total_q + HALF) >>> FRAC_BITS;
    dout_d = rnd[DW-1:0];
    if (relu_s3_q && rnd[AW-1]) begin
      dout_d = '0;
    end else if (rnd > SAT_MAX) begin
      dout_d = OUT_MAX;
    end else if (rnd < SAT_MIN) begin
      dout_d = OUT_MIN;
    end
  end

  // Datapath pipeline; stage payloads only load alongside their valid bit, so in-flight
  // windows keep the weights, bias and relu_en captured with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAP; k++) prod_q[k] <= '0;
      for (int r = 0; r < NROW; r++) row_q[r] <= '0;
      bias_s1_q <= '0;
      bias_s2_q <= '0;
      relu_s1_q <= 1'b0;
      relu_s2_q <= 1'b0;
      relu_s3_q <= 1'b0;
      total_q   <= '0;
      dout_q    <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      vout_q    <= 1'b0;
    end else begin
      v1_q   <= accept;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      vout_q <= v3_q;
      if (accept) begin
        for (int k = 0; k < NTAP; k++) prod_q[k] <= PW'(din[k]) * PW'(kern_q[k]);
        bias_s1_q <= bias_q;
        relu_s1_q <= relu_en;
      end
      if (v1_q) begin
        for (int r = 0; r < NROW; r++) begin
          row_q[r] <= AW'(prod_q[3*r]) + AW'(prod_q[3*r+1]) + AW'(prod_q[3*r+2]);
        end
        bias_s2_q <= bias_s1_q;
        relu_s2_q <= relu_s1_q;
      end
      if (v2_q) begin
        total_q   <= row_q[0] + row_q[1] + row_q[2] + (AW'(bias_s2_q) <<< FRAC_BITS);
        relu_s3_q <= relu_s2_q;
      end
      if (v3_q) dout_q <= dout_d;
    end
  end

  assign data_out      = dout_q;
  assign valid_out     = vout_q;
  assign weights_ready = ready_q;
  assign drop_err      = drop_q;

endmodule
